alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//   Upstream feeder for the 6-bit combinational ALU (module ALU).
//   - Accepts (A, B, op) commands over a valid/ready handshake into a DEPTH-entry FIFO.
//   - Pops one command at a time and holds it stable on registered ALU operand outputs.
//   - Captures the ALU result and presents it downstream with its op code over a second valid/ready handshake.
// PARAMETERS
//   DATA_W  6  operand/result width, matching the ALU
//   OP_W    2  op code width; the op code is passed through opaque, never decoded here
//   DEPTH   4  command FIFO entries; must be a power of 2 and >= 2
// PORTS
//   clk        in   1                  rising-edge clock
//   rst        in   1                  asynchronous, active-high reset
//   in_valid   in   1                  command present on in_a/in_b/in_op
//   in_ready   out  1                  FIFO can accept a command
//   in_a       in   DATA_W             operand A, two's complement
//   in_b       in   DATA_W             operand B, two's complement
//   in_op      in   OP_W               ALU op code
//   alu_a      out  DATA_W             registered operand A to the ALU
//   alu_b      out  DATA_W             registered operand B to the ALU
//   alu_op     out  OP_W               registered op code to the ALU
//   alu_out    in   DATA_W             combinational ALU result
//   res_valid  out  1                  res_data/res_op hold a result
//   res_ready  in   1                  downstream takes the result
//   res_data   out  DATA_W             captured ALU result
//   res_op     out  OP_W               op code that produced res_data
//   fifo_count out  $clog2(DEPTH)+1    commands currently queued
// BEHAVIOUR
//   Reset: all outputs and state go to 0 (including in_ready), FIFO empty, FSM=IDLE; in_ready = 1 after rst deasserts.
//   Reset mid-operation: queued and in-flight commands are discarded; no result is emitted for them.
//   Push:
//     - in_ready = (fifo_count < DEPTH); there is no bypass while full, even if a pop happens that cycle.
//     - A push occurs on in_valid && in_ready.
//   FIFO pointers: wrap modulo DEPTH.
//     - Simultaneous push and pop leaves fifo_count unchanged.
//     - Ordering is strictly FIFO.
//   FSM states, as constants in the shared package:
//     IDLE : if fifo_count>0, pop head into alu_a/alu_b/alu_op and go to DRIVE; else stay.
//     DRIVE: ALU inputs are held for one full cycle.
//            At the next edge, res_data<=alu_out, res_op<=alu_op, res_valid<=1; go to WAIT.
//     WAIT : hold res_* and alu_* stable while !res_ready.
//            On res_valid && res_ready: if fifo_count>0, pop the next command and go to DRIVE (res_valid<=0);
//            else res_valid<=0 and go to IDLE.
//   Latency:
//     - A command pushed at edge k into an empty FIFO with FSM=IDLE is popped at edge k+1.
//     - Its res_valid is high after edge k+2.
//   Throughput: one result per 2 cycles with res_ready held at 1.
//   A command pushed in the same cycle the FIFO goes empty is not visible to a pop until the following cycle.
//   Width: no arithmetic is done here. Data passes through bit-exact, so two's-complement operands such as -5 = 6'b111011 are preserved.
//   alu_* keep their last value in IDLE; they do not return to 0.
// STRUCTURE
//   Shared package alu_pkg:
//     - DATA_W and OP_W defaults
//     - FSM state localparams ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_WAIT=2'd2
//   Sub-module alu_cmd_fifo: a synchronous FIFO of {a,b,op} with push/pop, count, full and empty; same clk/rst.
//   Top level: the FSM and the output registers.
// TESTING (bench instantiates ALU and alu_cmd_sequencer together; expected result = ALU evaluated on the same inputs)
//   1. Reset mid-stream: assert rst with 3 commands queued.
//      -> fifo_count=0, res_valid=0, alu_a=0 at once.
//      -> After release, no result is emitted for the dropped commands.
//   2. Single command: push A=-5 (111011), B=20 (010100), op=0 at edge k.
//      -> alu_a=111011 and alu_b=010100 after edge k+1.
//      -> res_valid=1 after edge k+2, with res_data=ALU(111011,010100,0) and res_op=0.
//   3. Fill: push 4 commands with res_ready=0.
//      -> in_ready=0 when fifo_count=4.
//      -> A 5th command held on in_valid is not taken until after a result handshake.
//   4. Back-to-back: queue (5,10,1), (5,20,2), (-3,-10,3), (3,2,1) and hold res_ready=1.
//      -> 4 results arrive in order, res_valid is high every other cycle, and res_op sequence = 1,2,3,1.
//   5. Backpressure: hold res_ready=0 for 5 cycles while a result is pending.
//      -> res_data, res_op and alu_* are stable; fifo_count does not decrease.
//   6. Simultaneous push and pop at fifo_count=2.
//      -> fifo_count stays 2, and order is preserved after pointer wrap (push more than 8 commands).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: default widths and FSM encoding.
package alu_pkg;

  localparam int DATA_W = 6;
  localparam int OP_W   = 2;
  localparam int DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle between upstream/downstream agents and the sequencer.
interface alu_cmd_sequencer_if
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [OP_W-1:0]   in_op;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [OP_W-1:0]   res_op;

  modport master (
    output in_valid, in_a, in_b, in_op, res_ready,
    input  in_ready, res_valid, res_data, res_op
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, res_ready,
    output in_ready, res_valid, res_data, res_op
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; in_ready-style 'ready' is registered from the next-cycle count.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int DEPTH = alu_pkg::DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   ready
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             ready_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // No push while full, even if a pop happens in the same cycle.
  assign push_ok_s = push && ready_r;
  assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s < CNT_W'(DEPTH));
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign ready = ready_r;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives them one at a time onto registered ALU inputs and
// returns each captured result with its op code over a valid/ready handshake.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W,
  parameter int DEPTH  = alu_pkg::DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_cmd_sequencer_if.slave     bus,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OP_W-1:0]        alu_op,
  input  logic [DATA_W-1:0]      alu_out,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CMD_W = 2 * DATA_W + OP_W;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CMD_W-1:0]  head_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic              ready_s;
  logic              res_take_s;
  logic [DATA_W-1:0] alu_a_r;
  logic [DATA_W-1:0] alu_b_r;
  logic [OP_W-1:0]   alu_op_r;
  logic              res_valid_r;
  logic [DATA_W-1:0] res_data_r;
  logic [OP_W-1:0]   res_op_r;

  assign push_s     = bus.in_valid && ready_s && !full_s;
  assign res_take_s = res_valid_r && bus.res_ready;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({bus.in_a, bus.in_b, bus.in_op}),
    .rdata (head_s),
    .count (fifo_count),
    .full  (full_s),
    .empty (empty_s),
    .ready (ready_s)
  );

  // Next state and pop request.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_DRIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (res_take_s) begin
          if (!empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_DRIVE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, ALU operand and result registers; ALU operands hold their last value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      alu_a_r     <= {DATA_W{1'b0}};
      alu_b_r     <= {DATA_W{1'b0}};
      alu_op_r    <= {OP_W{1'b0}};
      res_valid_r <= 1'b0;
      res_data_r  <= {DATA_W{1'b0}};
      res_op_r    <= {OP_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (pop_s) begin
        {alu_a_r, alu_b_r, alu_op_r} <= head_s;
      end
      if (state_r == ST_DRIVE) begin
        res_data_r  <= alu_out;
        res_op_r    <= alu_op_r;
        res_valid_r <= 1'b1;
      end else if (state_r == ST_WAIT && res_take_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign alu_a         = alu_a_r;
  assign alu_b         = alu_b_r;
  assign alu_op        = alu_op_r;
  assign bus.in_ready  = ready_s;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_op    = res_op_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU stand-in on alu_out.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] alu_a, alu_b, alu_out;
  logic [1:0] alu_op;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus_if ();

  // ALU stand-in: 0 add, 1 sub, 2 and, 3 xor
  function automatic logic [5:0] alu_model(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_out = alu_model(alu_a, alu_b, alu_op);

  alu_cmd_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .fifo_count (fifo_count)
  );

  typedef struct {
    logic [5:0] data;
    logic [1:0] op;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: compare every result handshake against the scoreboard
  always @(negedge clk) begin
    if (!rst && bus_if.res_valid && bus_if.res_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got data %0d op %0d, required no result",
                 bus_if.res_data, bus_if.res_op);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data", int'(bus_if.res_data), int'(e.data));
        check("res_op", int'(bus_if.res_op), int'(e.op));
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge
  task automatic push_cmd(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op, input logic [5:0] r);
    int n;
    exp_t e;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
    bus_if.in_op    = op;
    bus_if.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus_if.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.in_ready) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got in_ready 0, required 1");
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      e.data = r;
      e.op   = op;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (!bus_if.res_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus_if.res_valid) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: got res_valid 0, required 1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] ops;
    logic       seen;
    int         k;

    bus_if.in_valid  = 1'b0;
    bus_if.in_a      = 6'd0;
    bus_if.in_b      = 6'd0;
    bus_if.in_op     = 2'd0;
    bus_if.res_ready = 1'b0;

    // Reset state
    #2;
    check("rst_count", int'(fifo_count), 0);
    check("rst_in_ready", int'(bus_if.in_ready), 0);
    check("rst_res_valid", int'(bus_if.res_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", int'(bus_if.in_ready), 1);

    // 1. Reset mid-stream with 3 commands queued and one in flight
    push_cmd(6'd10, 6'd1, 2'd0, 6'd11);
    push_cmd(6'd2, 6'd3, 2'd0, 6'd5);
    push_cmd(6'd4, 6'd4, 2'd0, 6'd8);
    push_cmd(6'd6, 6'd1, 2'd1, 6'd5);
    check("mid_count", int'(fifo_count), 3);
    rst = 1'b1;
    #1;
    check("midrst_count", int'(fifo_count), 0);
    check("midrst_res_valid", int'(bus_if.res_valid), 0);
    check("midrst_alu_a", int'(alu_a), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus_if.res_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | bus_if.res_valid;
    end
    check("dropped_no_result", int'(seen), 0);
    check("post_rst_in_ready", int'(bus_if.in_ready), 1);

    // 2. Single command latency, two's-complement pass-through
    @(posedge clk);
    #1;
    bus_if.res_ready = 1'b0;
    bus_if.in_a      = 6'b111011;
    bus_if.in_b      = 6'b010100;
    bus_if.in_op     = 2'd0;
    bus_if.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    exp_q.push_back('{6'd15, 2'd0});
    check("lat_count_k", int'(fifo_count), 1);
    @(posedge clk);
    #1;
    check("lat_alu_a", int'(alu_a), int'(6'b111011));
    check("lat_alu_b", int'(alu_b), int'(6'b010100));
    check("lat_valid_k1", int'(bus_if.res_valid), 0);
    @(posedge clk);
    #1;
    check("lat_valid_k2", int'(bus_if.res_valid), 1);
    check("lat_res_data", int'(bus_if.res_data), 15);
    check("lat_res_op", int'(bus_if.res_op), 0);
    bus_if.res_ready = 1'b1;
    drain();

    // 3. Fill the FIFO, then hold a further command until a result handshake
    bus_if.res_ready = 1'b0;
    push_cmd(6'd1, 6'd2, 2'd0, 6'd3);
    push_cmd(6'd7, 6'd1, 2'd1, 6'd6);
    push_cmd(6'd12, 6'd10, 2'd2, 6'd8);
    push_cmd(6'd6, 6'd3, 2'd3, 6'd5);
    push_cmd(6'd20, 6'd11, 2'd0, 6'd31);
    check("full_count", int'(fifo_count), 4);
    check("full_in_ready", int'(bus_if.in_ready), 0);
    bus_if.in_a     = 6'd31;
    bus_if.in_b     = 6'd1;
    bus_if.in_op    = 2'd0;
    bus_if.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("full_hold_count", int'(fifo_count), 4);
    bus_if.res_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus_if.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("full_release_ready", int'(bus_if.in_ready), 1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    exp_q.push_back('{6'd32, 2'd0});
    drain();

    // 4. Back-to-back results with res_ready held high
    bus_if.res_ready = 1'b0;
    push_cmd(6'd5, 6'd10, 2'd1, 6'b111011);
    push_cmd(6'd5, 6'd20, 2'd2, 6'd4);
    push_cmd(6'b111101, 6'b110110, 2'd3, 6'b001011);
    push_cmd(6'd3, 6'd2, 2'd1, 6'd1);
    wait_result();
    bus_if.res_ready = 1'b1;
    pat = 8'd0;
    ops = 8'd0;
    k   = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[i] = bus_if.res_valid;
      if (bus_if.res_valid && k < 4) begin
        ops[2*k +: 2] = bus_if.res_op;
        k++;
      end
    end
    check("b2b_valid_pattern", int'(pat), int'(8'b01010101));
    check("b2b_op_sequence", int'(ops), int'({2'd1, 2'd3, 2'd2, 2'd1}));
    drain();

    // 5. Backpressure: result and ALU inputs hold while res_ready is low
    bus_if.res_ready = 1'b0;
    push_cmd(6'd9, 6'd4, 2'd1, 6'd5);
    push_cmd(6'd2, 6'd2, 2'd0, 6'd4);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", int'({bus_if.res_data, bus_if.res_op, alu_a, alu_b, fifo_count}),
            int'({6'd5, 2'd1, 6'd9, 6'd4, 3'd1}));
    end
    @(posedge clk);
    #1;
    bus_if.res_ready = 1'b1;
    drain();

    // 6. Simultaneous push and pop at count 2, then stream across pointer wraps
    bus_if.res_ready = 1'b0;
    push_cmd(6'd3, 6'd4, 2'd0, 6'd7);
    push_cmd(6'd8, 6'd8, 2'd0, 6'd16);
    push_cmd(6'd1, 6'd30, 2'd0, 6'd31);
    wait_result();
    @(posedge clk);
    #1;
    bus_if.in_a      = 6'd2;
    bus_if.in_b      = 6'd5;
    bus_if.in_op     = 2'd0;
    bus_if.in_valid  = 1'b1;
    bus_if.res_ready = 1'b1;
    @(negedge clk);
    check("pp_count_before", int'(fifo_count), 2);
    check("pp_in_ready", int'(bus_if.in_ready), 1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    exp_q.push_back('{6'd7, 2'd0});
    check("pp_count_after", int'(fifo_count), 2);
    for (int i = 0; i < 10; i++) begin
      push_cmd(6'(i + 4), 6'(i), 2'd0, 6'(2 * i + 4));
    end
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
